// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO family.
// addr_width() gives the pointer/count width for a given depth: enough bits
// to index every entry plus one wrap bit, so that a full FIFO (count == depth)
// is distinguishable from an empty one.
package sync_fifo_ctrl_pkg;

  function automatic int addr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_mem.sv
// Storage array for the synchronous FIFO.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - write data
//   i_raddr  - read index (asynchronous read)
//   o_rdata  - entry at i_raddr
module sync_fifo_ctrl_mem #(
  parameter int fifo_width = 8,
  parameter int fifo_depth = 16,
  parameter int idx_width  = $clog2(fifo_depth)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [idx_width-1:0]  i_waddr,
  input  logic [fifo_width-1:0] i_wdata,
  input  logic [idx_width-1:0]  i_raddr,
  output logic [fifo_width-1:0] o_rdata
);

  logic [fifo_width-1:0] r_mem [fifo_depth];

  // NOTE: storage has no reset; validity is tracked by the pointers, and
  // leaving the array unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags,
// sticky error flags and read-data register around sync_fifo_ctrl_mem.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   flush         - synchronous clear of contents and error flags
//   write_en/data - push request and data
//   read_en       - pop request
//   read_data     - registered (fwft=0) or head-of-queue (fwft=1) data
//   read_valid    - fwft=0: read_data updated this cycle; fwft=1: !empty
//   empty, full, almost_empty, almost_full, count - occupancy status
//   overflow, underflow - sticky: write while full / read while empty
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int fifo_width = 8,
  parameter int fifo_depth = 16,
  parameter int af_thresh  = fifo_depth - 2,
  parameter int ae_thresh  = 1,
  parameter bit fwft       = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                write_en,
  input  logic [fifo_width-1:0]               write_data,
  input  logic                                read_en,
  output logic [fifo_width-1:0]               read_data,
  output logic                                read_valid,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_empty,
  output logic                                almost_full,
  output logic [addr_width(fifo_depth)-1:0]   count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int AS = addr_width(fifo_depth);
  localparam int IW = AS - 1;

  logic [AS-1:0]         r_wr_ptr, r_rd_ptr, r_count;
  logic [fifo_width-1:0] r_read_data;
  logic                  r_read_valid, r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc;
  logic [fifo_width-1:0] w_head;

  // Flags decode the count register only, so they are glitch-free w.r.t.
  // the request inputs.
  assign empty        = (r_count == '0);
  assign full         = (r_count == AS'(fifo_depth));
  assign almost_empty = (r_count <= AS'(ae_thresh));
  assign almost_full  = (r_count >= AS'(af_thresh));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Acceptance uses pre-edge flags; flush suppresses both sides.
  assign w_wr_acc = write_en && !full  && !flush;
  assign w_rd_acc = read_en  && !empty && !flush;

  sync_fifo_ctrl_mem #(
    .fifo_width (fifo_width),
    .fifo_depth (fifo_depth),
    .idx_width  (IW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[IW-1:0]),
    .i_wdata (write_data),
    .i_raddr (r_rd_ptr[IW-1:0]),
    .o_rdata (w_head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (write_en && full) r_overflow  <= 1'b1;
      if (read_en && empty) r_underflow <= 1'b1;

      r_read_valid <= w_rd_acc;
      if (fwft) begin
        // Shadow of the head so read_data stays stable once the FIFO drains.
        if (!empty) r_read_data <= w_head;
      end else if (w_rd_acc) begin
        r_read_data <= w_head;
      end
    end
  end

  assign read_data  = (fwft && !empty) ? w_head : r_read_data;
  assign read_valid = fwft ? !empty : r_read_valid;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench: a standard-mode instance (s_*) and an FWFT instance (f_*),
// both 8 bits x 8 entries, af_thresh=6, ae_thresh=1.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s_flush, s_we, s_re;
  logic [7:0] s_wdata, s_rdata;
  logic       s_rvalid, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic [3:0] s_count;

  logic       f_flush, f_we, f_re;
  logic [7:0] f_wdata, f_rdata;
  logic       f_rvalid, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [3:0] f_count;

  sync_fifo_ctrl #(.fifo_width(8), .fifo_depth(8), .af_thresh(6),
                   .ae_thresh(1), .fwft(1'b0)) dut_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .write_en(s_we), .write_data(s_wdata), .read_en(s_re),
    .read_data(s_rdata), .read_valid(s_rvalid), .empty(s_empty),
    .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(.fifo_width(8), .fifo_depth(8), .af_thresh(6),
                   .ae_thresh(1), .fwft(1'b1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush),
    .write_en(f_we), .write_data(f_wdata), .read_en(f_re),
    .read_data(f_rdata), .read_valid(f_rvalid), .empty(f_empty),
    .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_flush = 0; s_we = 0; s_re = 0; s_wdata = '0;
    f_flush = 0; f_we = 0; f_re = 0; f_wdata = '0;
    #12;
    check("rst_count", 32'(s_count), 0);
    check("rst_empty", 32'(s_empty), 1);
    check("rst_ae", 32'(s_ae), 1);
    check("rst_full", 32'(s_full), 0);
    check("rst_af", 32'(s_af), 0);
    check("rst_rvalid", 32'(s_rvalid), 0);
    check("rst_rdata", 32'(s_rdata), 0);
    check("rst_ovf", 32'(s_ovf), 0);
    check("rst_unf", 32'(s_unf), 0);
    check("rst_f_empty", 32'(f_empty), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill 0x00..0x07 and watch the flags cross their thresholds.
    for (int i = 0; i < 8; i++) begin
      s_we = 1; s_wdata = 8'(i);
      tick();
      check($sformatf("fill_count%0d", i), 32'(s_count), 32'(i + 1));
      check($sformatf("fill_full%0d", i), 32'(s_full), 32'(i + 1 == 8));
      check($sformatf("fill_af%0d", i), 32'(s_af), 32'(i + 1 >= 6));
      check($sformatf("fill_ae%0d", i), 32'(s_ae), 32'(i + 1 <= 1));
    end

    // Full: write 0xFF with a read -> read accepted, write rejected.
    s_wdata = 8'hFF; s_re = 1;
    tick();
    s_we = 0; s_re = 0;
    check("ovf_rdata", 32'(s_rdata), 32'h00);
    check("ovf_rvalid", 32'(s_rvalid), 1);
    check("ovf_count", 32'(s_count), 7);
    check("ovf_flag", 32'(s_ovf), 1);

    // Drain the rest: 0x01..0x07, never 0xFF.
    for (int i = 1; i < 8; i++) begin
      s_re = 1;
      tick();
      check($sformatf("drain_rdata%0d", i), 32'(s_rdata), 32'(i));
      check($sformatf("drain_rvalid%0d", i), 32'(s_rvalid), 1);
    end
    s_re = 0;
    check("drain_empty", 32'(s_empty), 1);
    check("ovf_sticky", 32'(s_ovf), 1);
    tick();
    check("idle_rvalid", 32'(s_rvalid), 0);
    check("idle_rdata_hold", 32'(s_rdata), 32'h07);

    // Underflow on empty read.
    s_re = 1;
    tick();
    s_re = 0;
    check("unf_rvalid", 32'(s_rvalid), 0);
    check("unf_rdata_hold", 32'(s_rdata), 32'h07);
    check("unf_flag", 32'(s_unf), 1);
    check("unf_count", 32'(s_count), 0);

    // Flush with write+read requests: flush wins, no new errors.
    s_flush = 1; s_we = 1; s_wdata = 8'h99; s_re = 1;
    tick();
    s_flush = 0; s_we = 0; s_re = 0;
    check("flush_unf", 32'(s_unf), 0);
    check("flush_ovf", 32'(s_ovf), 0);
    check("flush_count", 32'(s_count), 0);
    check("flush_empty", 32'(s_empty), 1);
    check("flush_rdata_hold", 32'(s_rdata), 32'h07);

    // Fill 4, then 20 cycles of simultaneous write/read across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      s_we = 1; s_wdata = 8'(8'h10 + i);
      tick();
    end
    check("steady_pre_count", 32'(s_count), 4);
    for (int i = 0; i < 20; i++) begin
      s_we = 1; s_re = 1; s_wdata = 8'(8'h14 + i);
      tick();
      check($sformatf("steady_rdata%0d", i), 32'(s_rdata), 32'(8'h10 + i));
      check($sformatf("steady_count%0d", i), 32'(s_count), 4);
    end
    s_re = 0;
    s_wdata = 8'h55;
    tick();
    s_we = 0;
    check("burst_count5", 32'(s_count), 5);

    // FWFT instance.
    f_we = 1; f_wdata = 8'hA5;
    tick();
    f_we = 0;
    check("fwft_empty", 32'(f_empty), 0);
    check("fwft_rdata", 32'(f_rdata), 32'hA5);
    check("fwft_rvalid", 32'(f_rvalid), 1);
    f_re = 1;
    tick();
    f_re = 0;
    check("fwft_pop_empty", 32'(f_empty), 1);
    check("fwft_pop_rvalid", 32'(f_rvalid), 0);
    check("fwft_pop_rdata_stable", 32'(f_rdata), 32'hA5);
    f_we = 1; f_wdata = 8'h11;
    tick();
    f_wdata = 8'h22;
    tick();
    f_we = 0;
    check("fwft_head1", 32'(f_rdata), 32'h11);
    f_re = 1;
    tick();
    f_re = 0;
    check("fwft_head2", 32'(f_rdata), 32'h22);
    check("fwft_count", 32'(f_count), 1);

    // Asynchronous reset mid-cycle with the standard FIFO at count 5.
    check("pre_rst_count", 32'(s_count), 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(s_count), 0);
    check("arst_empty", 32'(s_empty), 1);
    check("arst_af", 32'(s_af), 0);
    check("arst_full", 32'(s_full), 0);
    check("arst_rdata", 32'(s_rdata), 0);
    check("arst_f_count", 32'(f_count), 0);
    #1 rst_n = 1'b1;
    s_we = 1; s_wdata = 8'h3C;
    tick();
    s_we = 0; s_re = 1;
    tick();
    s_re = 0;
    check("post_rst_rdata", 32'(s_rdata), 32'h3C);
    check("post_rst_rvalid", 32'(s_rvalid), 1);
    check("post_rst_empty", 32'(s_empty), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
